mar_access_sequencer: RTL and testbench
=======================================

// Module: mar_access_sequencer
// PURPOSE
//  Shares the MAR and main memory between two requesters: instruction fetch (F) and data access (D).
//  Each transaction is sequenced as:
//    - load the MAR (mar_L/mar_in);
//    - hold a memory read or write strobe for WAIT_CYCLES cycles;
//    - return read data with a one-cycle done pulse.
//  Sits between the control unit and the MAR/RAM pair; it is the only driver of the MAR load enable.
// PARAMETERS
//  AW           8  address width (matches the MAR)
//  DW           8  data width
//  WAIT_CYCLES  1  cycles the memory strobe is held; legal range 1..15
// PORTS
//  clk        in   1   system clock; all state changes on posedge
//  clr        in   1   reset, synchronous, active-high
//  f_req      in   1   fetch request; held high until f_done
//  f_addr     in   AW  fetch address; stable while f_req
//  f_done     out  1   one-cycle pulse; fetch transaction complete, rdata valid
//  d_req      in   1   data request; held high until d_done
//  d_we       in   1   1 = write, 0 = read; stable while d_req
//  d_addr     in   AW  data address
//  d_wdata    in   DW  write data
//  d_done     out  1   one-cycle pulse; data transaction complete
//  rdata      out  DW  registered read data; holds its value until the next read completes
//  mar_L      out  1   MAR load enable
//  mar_in     out  AW  MAR load value
//  mem_rd     out  1   memory read strobe
//  mem_wr     out  1   memory write strobe
//  mem_wdata  out  DW  write data to memory
//  mem_rdata  in   DW  memory read data, addressed by the MAR output
//  busy       out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (clr=1 at a posedge):
//   - state=IDLE, all outputs 0, rdata=0, wait counter=0, last_grant=D (F wins the first tie).
//  FSM (one state per cycle except ACCESS):
//   - IDLE: if f_req|d_req, pick a winner and go to LOAD.
//       - Winner is latched as owner, together with addr, we (F is always read) and wdata.
//       - No request: stay in IDLE.
//   - LOAD: mar_L=1, mar_in=latched addr. Next state ACCESS; counter=WAIT_CYCLES-1.
//   - ACCESS:
//       - Strobes: mem_rd=~we or mem_wr=we; mem_wdata=latched wdata.
//       - Held for exactly WAIT_CYCLES cycles. On the final cycle (counter==0) on a read, rdata<=mem_rdata.
//       - Next state DONE.
//   - DONE: pulse owner's done; last_grant<=owner; next state IDLE.
//  Outputs:
//   - All outputs are decoded from the registered state and latched fields; no combinational path req->strobe.
//   - mar_L and the memory strobes are never high in the same cycle.
//  Latency:
//   - req first high in IDLE cycle 0 -> mar_L in cycle 1 -> strobes in cycles 2..1+WAIT_CYCLES -> done in cycle 2+WAIT_CYCLES.
//   - Next grant is earliest in cycle 3+WAIT_CYCLES (IDLE).
//  Arbitration:
//   - Both requests high in IDLE: grant the requester that is not last_grant (round-robin).
//   - Only one request high: grant it.
//  Requester rule:
//   - Deassert req at the edge ending the done cycle, or reissue it as a new request.
//   - req is sampled in IDLE only; changes in other states are ignored.
//   - Address and data are latched in IDLE, so later changes cannot corrupt the transaction in flight.
//  Write:
//   - rdata is unchanged.
//  Reset mid-transaction:
//   - clr in any state returns to IDLE at that edge; strobes drop.
//   - No done is issued; the aborted requester must reissue.
//   - The MAR is cleared by the same clr at the system level.
//  Counter is 4 bits wide. WAIT_CYCLES=0 is illegal: flag it with an initial/elaboration check.
// STRUCTURE
//  Shared package/header (sap_ctrl_defs):
//   - state encodings IDLE/LOAD/ACCESS/DONE (2-bit);
//   - requester IDs REQ_F=0, REQ_D=1.
//  One sub-module: rr_arb2 (two-way round-robin picker; inputs req[1:0], last; output grant id). The FSM stays in this file.
// TESTING
//  1. clr for 2 cycles, then release -> all outputs 0, busy=0, rdata=8'h00.
//  2. F read, f_addr=8'h32, mem model returns 8'hA5 (W=1):
//       mar_L=1/mar_in=8'h32 at cycle 1; mem_rd at cycle 2; f_done and rdata=8'hA5 at cycle 3.
//  3. D write, d_addr=8'h10, d_wdata=8'h5C, WAIT_CYCLES=3:
//       mem_wr high for exactly 3 cycles with mem_wdata=8'h5C; d_done at cycle 5; rdata unchanged.
//  4. f_req and d_req both held continuously after reset:
//       grant order F,D,F,D; done pulses alternate; no cycle has both done signals.
//  5. clr asserted during ACCESS of a D read:
//       next cycle IDLE, strobes 0, no d_done; a reissued request completes normally.
//  6. f_addr changed during ACCESS:
//       mar_in/memory access use the address sampled in IDLE; the bench checks MAR contents equal the original address.

Source files
------------

// File: rtl/sap_ctrl_defs.sv
// Shared definitions for the MAR access sequencer: FSM state encoding,
// requester IDs and the wait-counter width.
package sap_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  localparam int CNT_W = 4;

endpackage : sap_ctrl_defs

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the
// requester that was not granted last time wins.
module rr_arb2
  import sap_ctrl_defs::*;
(
  input  logic [1:0] req,    // [0] = fetch, [1] = data
  input  req_id_t    last,
  output req_id_t    grant
);

  // Pick the winner; the result only matters when at least one request is high.
  always_comb begin
    // NOTE: assign a default before any condition so every path drives grant and no latch is inferred.
    grant = REQ_F;
    if (req[1] && (!req[0] || last == REQ_F)) begin
      grant = REQ_D;
    end
  end

endmodule : rr_arb2

// File: rtl/mar_access_sequencer.sv
// Shares the MAR and main memory between instruction fetch (F) and data
// access (D). Each transaction: load MAR, hold a read/write strobe for
// WAIT_CYCLES cycles, then pulse the owner's done. Every output is a register.
module mar_access_sequencer
  import sap_ctrl_defs::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          mar_L,
  output logic [AW-1:0] mar_in,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // The strobe length must fit the 4-bit counter and be at least one cycle.
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mar_access_sequencer: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  req_id_t          owner;
  req_id_t          last_grant;
  req_id_t          grant;
  logic             we_q;
  logic [DW-1:0]    wdata_q;
  logic [CNT_W-1:0] cnt;

  rr_arb2 u_arb (
    .req   ({d_req, f_req}),
    .last  (last_grant),
    .grant (grant)
  );

  // Sequencer FSM; outputs are registered to match the state being entered.
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= IDLE;
      owner      <= REQ_F;
      last_grant <= REQ_D;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt        <= '0;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
      rdata      <= '0;
      mar_L      <= 1'b0;
      mar_in     <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req || d_req) begin
            owner <= grant;
            if (grant == REQ_F) begin
              mar_in  <= f_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end else begin
              mar_in  <= d_addr;
              we_q    <= d_we;
              wdata_q <= d_wdata;
            end
            mar_L <= 1'b1;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          mar_L     <= 1'b0;
          mem_rd    <= ~we_q;
          mem_wr    <= we_q;
          mem_wdata <= wdata_q;
          cnt       <= CNT_INIT;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (cnt == '0) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (!we_q) begin
              rdata <= mem_rdata;
            end
            f_done <= (owner == REQ_F);
            d_done <= (owner == REQ_D);
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          last_grant <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : mar_access_sequencer

// File: tb/tb_mar_access_sequencer.sv
// Bench for mar_access_sequencer: one instance with WAIT_CYCLES=1 driven from
// a vector table, one with WAIT_CYCLES=3 for the multi-cycle sequences.
module tb_mar_access_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  // WAIT_CYCLES = 1 instance
  logic       f_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [7:0] f_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic       f_done1, d_done1, mar_l1, mem_rd1, mem_wr1, busy1;
  logic [7:0] rdata1, mar_in1, mem_wdata1, mem_rdata1, mar1;

  // WAIT_CYCLES = 3 instance
  logic       f_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
  logic [7:0] f_addr3 = '0, d_addr3 = '0, d_wdata3 = '0;
  logic       f_done3, d_done3, mar_l3, mem_rd3, mem_wr3, busy3;
  logic [7:0] rdata3, mar_in3, mem_wdata3, mem_rdata3, mar3;

  mar_access_sequencer #(.AW(8), .DW(8), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .clr(clr),
    .f_req(f_req1), .f_addr(f_addr1), .f_done(f_done1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_done(d_done1),
    .rdata(rdata1), .mar_L(mar_l1), .mar_in(mar_in1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .busy(busy1)
  );

  mar_access_sequencer #(.AW(8), .DW(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .clr(clr),
    .f_req(f_req3), .f_addr(f_addr3), .f_done(f_done3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3), .d_done(d_done3),
    .rdata(rdata3), .mar_L(mar_l3), .mar_in(mar_in3),
    .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .busy(busy3)
  );

  // Fixed read-only memory contents; unlisted addresses return the inverted address.
  function automatic logic [7:0] mem_model(input logic [7:0] a);
    case (a)
      8'h32:   mem_model = 8'hA5;
      8'h40:   mem_model = 8'h11;
      8'h50:   mem_model = 8'h22;
      8'h20:   mem_model = 8'h77;
      8'h60:   mem_model = 8'h9A;
      default: mem_model = a ^ 8'hFF;
    endcase
  endfunction

  // MAR models: cleared by clr, loaded by mar_L.
  always_ff @(posedge clk) begin
    if (clr) mar1 <= '0;
    else if (mar_l1) mar1 <= mar_in1;
  end
  always_ff @(posedge clk) begin
    if (clr) mar3 <= '0;
    else if (mar_l3) mar3 <= mar_in3;
  end
  assign mem_rdata1 = mem_model(mar1);
  assign mem_rdata3 = mem_model(mar3);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       f_req;
    logic [7:0] f_addr;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       mar_l;
    logic [7:0] mar_in;
    logic       mem_rd;
    logic       mem_wr;
    logic       f_done;
    logic       d_done;
    logic [7:0] rdata;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fr, input logic [7:0] fa, input logic dr,
                              input logic dwe, input logic [7:0] da, input logic [7:0] dwd,
                              input logic ml, input logic [7:0] mi, input logic rd,
                              input logic wr, input logic fd, input logic dd,
                              input logic [7:0] rdv, input logic bz);
    vec_t v;
    v.f_req = fr;  v.f_addr = fa;  v.d_req = dr;  v.d_we = dwe;
    v.d_addr = da; v.d_wdata = dwd; v.mar_l = ml; v.mar_in = mi;
    v.mem_rd = rd; v.mem_wr = wr;  v.f_done = fd; v.d_done = dd;
    v.rdata = rdv; v.busy = bz;
    return v;
  endfunction

  // Entry i holds the outputs expected during cycle i and the inputs driven for it.
  task automatic run_table(input int lo, input int hi);
    vec_t v;
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      v = vecs[i];
      check($sformatf("vec%0d mar_L", i), mar_l1, v.mar_l);
      if (v.mar_l) check($sformatf("vec%0d mar_in", i), mar_in1, v.mar_in);
      check($sformatf("vec%0d mem_rd", i), mem_rd1, v.mem_rd);
      check($sformatf("vec%0d mem_wr", i), mem_wr1, v.mem_wr);
      check($sformatf("vec%0d f_done", i), f_done1, v.f_done);
      check($sformatf("vec%0d d_done", i), d_done1, v.d_done);
      check($sformatf("vec%0d rdata", i), rdata1, v.rdata);
      check($sformatf("vec%0d busy", i), busy1, v.busy);
      f_req1 = v.f_req; f_addr1 = v.f_addr;
      d_req1 = v.d_req; d_we1 = v.d_we; d_addr1 = v.d_addr; d_wdata1 = v.d_wdata;
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    f_req1 = 1'b0; d_req1 = 1'b0; f_req3 = 1'b0; d_req3 = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int wr_cycles;
    int lat;
    logic is_f;
    logic [7:0] prev_rd, new_rd;

    // F read of 0x32 (returns 0xA5), one wait cycle
    vecs.push_back(mk(1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0));
    vecs.push_back(mk(1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1));
    vecs.push_back(mk(1'b1, 8'h32, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1));
    vecs.push_back(mk(1'b0, 8'h32, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0));
    // Both requesters held after reset: F(0x40->0x11), D(0x50->0x22), alternating
    for (int g = 0; g < 4; g++) begin
      is_f    = (g % 2 == 0);
      prev_rd = (g == 0) ? 8'h00 : ((g % 2 == 1) ? 8'h11 : 8'h22);
      new_rd  = is_f ? 8'h11 : 8'h22;
      vecs.push_back(mk(1'b1, 8'h40, 1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, prev_rd, 1'b0));
      vecs.push_back(mk(1'b1, 8'h40, 1'b1, 1'b0, 8'h50, 8'h00, 1'b1, is_f ? 8'h40 : 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, prev_rd, 1'b1));
      vecs.push_back(mk(1'b1, 8'h40, 1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, prev_rd, 1'b1));
      vecs.push_back(mk(1'b1, 8'h40, 1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, is_f, ~is_f, new_rd, 1'b1));
    end
    vecs.push_back(mk(1'b0, 8'h40, 1'b0, 1'b0, 8'h50, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0));

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset w1 outputs", {mar_l1, mar_in1, mem_rd1, mem_wr1, mem_wdata1, f_done1, d_done1, busy1}, 32'h0);
    check("reset w1 rdata", rdata1, 8'h00);
    check("reset w3 outputs", {mar_l3, mar_in3, mem_rd3, mem_wr3, mem_wdata3, f_done3, d_done3, busy3}, 32'h0);
    check("reset w3 rdata", rdata3, 8'h00);

    // Single F read
    run_table(0, 5);

    // D write, three wait cycles
    d_we3 = 1'b1; d_addr3 = 8'h10; d_wdata3 = 8'h5C; d_req3 = 1'b1;
    wr_cycles = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("wr c%0d mar_L", c), mar_l3, (c == 1));
      check($sformatf("wr c%0d mem_wr", c), mem_wr3, (c >= 2 && c <= 4));
      check($sformatf("wr c%0d mem_rd", c), mem_rd3, 1'b0);
      check($sformatf("wr c%0d d_done", c), d_done3, (c == 5));
      check($sformatf("wr c%0d f_done", c), f_done3, 1'b0);
      if (c == 1) check("wr mar_in", mar_in3, 8'h10);
      if (c == 2) check("wr mar", mar3, 8'h10);
      if (mem_wr3) begin
        wr_cycles++;
        check($sformatf("wr c%0d mem_wdata", c), mem_wdata3, 8'h5C);
      end
      if (c == 5) d_req3 = 1'b0;
    end
    check("wr strobe length", wr_cycles, 3);
    check("wr rdata unchanged", rdata3, 8'h00);

    // Round-robin with both requests held
    do_reset();
    run_table(5, 22);

    // clr during ACCESS of a D read, then reissue
    d_we3 = 1'b0; d_addr3 = 8'h20; d_req3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort in access", mem_rd3, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort busy", busy3, 1'b0);
    check("abort strobes", {mem_rd3, mem_wr3, mar_l3}, 3'b000);
    check("abort d_done", d_done3, 1'b0);
    d_req3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("abort quiet c%0d", c), {d_done3, busy3}, 2'b00);
    end
    d_req3 = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_done3) begin
        lat = k;
        break;
      end
    end
    d_req3 = 1'b0;
    check("reissue latency", lat, 5);
    check("reissue rdata", rdata3, 8'h77);

    // f_addr changes mid-transaction; the address sampled in IDLE is used
    @(negedge clk);
    f_addr3 = 8'h60; f_req3 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) check("addr hold mar_in", mar_in3, 8'h60);
      if (c == 2) f_addr3 = 8'h61;
      if (c == 3) check("addr hold mar c3", mar3, 8'h60);
      if (c == 4) check("addr hold mem_rd", {mem_rd3, mar3}, {1'b1, 8'h60});
      if (c == 5) begin
        check("addr hold f_done", f_done3, 1'b1);
        check("addr hold rdata", rdata3, 8'h9A);
        f_req3 = 1'b0;
      end
    end
    @(negedge clk);
    check("addr hold idle", {busy3, f_done3}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mar_access_sequencer
